// File: rtl/stack_ctrl_v2.sv
// Multicycle controller for the zero-address stack machine with a req/ready memory
// handshake and stack-occupancy tracking. Optional macro FAULT_RECOVER_EN adds fault_clr.
module stack_ctrl_v2 #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       opc,
   input  logic             zero,
   input  logic             mem_ready,
`ifdef FAULT_RECOVER_EN
   input  logic             fault_clr,
`endif
   output logic             mem_req,
   output logic             push,
   output logic             pop,
   output logic             ir_write,
   output logic             pc_write,
   output logic             old_pc_write,
   output logic             en2,
   output logic             en3,
   output logic             write_en,
   output logic             adr_src,
   output logic [1:0]       s1,
   output logic [1:0]       s2,
   output logic [1:0]       bus5_src,
   output logic [1:0]       bus8_src,
   output logic [1:0]       alu_control,
   output logic [CNT_W-1:0] sp_count,
   output logic             fault
);

   typedef enum logic [3:0] {
      S_IF         = 4'd0,
      S_ID         = 4'd1,
      S_PUSH_RD    = 4'd2,
      S_FIRST_POP  = 4'd3,
      S_SAVE_B     = 4'd4,
      S_SECOND_POP = 4'd5,
      S_SAVE_A     = 4'd6,
      S_CALC       = 4'd7,
      S_POP_WR     = 4'd8,
      S_JUMP       = 4'd9,
      S_FAULT      = 4'd10
   } state_e;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_clr_s;

`ifdef FAULT_RECOVER_EN
   assign fault_clr_s = fault_clr;
`else
   assign fault_clr_s = 1'b0;
`endif

   // True when executing op would push past DEPTH or pop an empty stack.
   function automatic logic stack_violation(input logic [2:0] op, input logic [CNT_W-1:0] cnt);
      logic viol;
      case (op)
         OP_PUSH:                viol = (cnt == CNT_FULL);
         OP_POP, OP_NOT:         viol = (cnt < CNT_ONE);
         OP_ADD, OP_SUB, OP_AND: viol = (cnt < CNT_TWO);
         default:                viol = 1'b0;
      endcase
      return viol;
   endfunction

   // State and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IF;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF: begin
            if (mem_ready) state_d = S_ID;
            else           state_d = S_IF;
         end
         S_ID: begin
            if (stack_violation(opc, cnt_q))             state_d = S_FAULT;
            else if (opc == OP_PUSH)                     state_d = S_PUSH_RD;
            else if (opc == OP_JMP)                      state_d = S_JUMP;
            else if (opc == OP_JZ && zero)               state_d = S_JUMP;
            else if (opc == OP_JZ)                       state_d = S_IF;
            else                                         state_d = S_FIRST_POP;
         end
         S_PUSH_RD: begin
            if (mem_ready) state_d = S_IF;
            else           state_d = S_PUSH_RD;
         end
         S_FIRST_POP: begin
            if (opc == OP_POP) state_d = S_POP_WR;
            else               state_d = S_SAVE_B;
         end
         S_SAVE_B: begin
            if (opc == OP_NOT) state_d = S_CALC;
            else               state_d = S_SECOND_POP;
         end
         S_SECOND_POP: state_d = S_SAVE_A;
         S_SAVE_A:     state_d = S_CALC;
         S_CALC:       state_d = S_IF;
         S_POP_WR: begin
            if (mem_ready) state_d = S_IF;
            else           state_d = S_POP_WR;
         end
         S_JUMP:       state_d = S_IF;
         S_FAULT: begin
            if (fault_clr_s) state_d = S_IF;
            else             state_d = S_FAULT;
         end
         default:      state_d = S_IF;
      endcase
   end

   // Occupancy follows the stack strobes; overflow/underflow are blocked in ID.
   always_comb begin
      cnt_d = cnt_q;
      case (state_q)
         S_PUSH_RD: begin
            if (mem_ready) cnt_d = cnt_q + CNT_ONE;
            else           cnt_d = cnt_q;
         end
         S_FIRST_POP, S_SECOND_POP: cnt_d = cnt_q - CNT_ONE;
         S_CALC:                    cnt_d = cnt_q + CNT_ONE;
         S_FAULT: begin
            if (fault_clr_s) cnt_d = CNT_ZERO;
            else             cnt_d = cnt_q;
         end
         default:                   cnt_d = cnt_q;
      endcase
   end

   // Moore outputs; memory-completion strobes are qualified by mem_ready.
   always_comb begin
      mem_req      = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      old_pc_write = 1'b0;
      en2          = 1'b0;
      en3          = 1'b0;
      write_en     = 1'b0;
      adr_src      = 1'b0;
      s1           = 2'b00;
      s2           = 2'b00;
      bus5_src     = 2'b00;
      bus8_src     = 2'b00;
      alu_control  = 2'b00;
      fault        = 1'b0;
      case (state_q)
         S_IF: begin
            mem_req      = 1'b1;
            s1           = 2'b01;
            s2           = 2'b01;
            bus5_src     = 2'b10;
            ir_write     = mem_ready;
            pc_write     = mem_ready;
            old_pc_write = mem_ready;
         end
         S_ID: begin
            s1 = 2'b10;
            s2 = 2'b10;
         end
         S_PUSH_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            push    = mem_ready;
         end
         S_FIRST_POP, S_SECOND_POP: pop = 1'b1;
         S_SAVE_B: begin
            bus8_src = 2'b01;
            en2      = 1'b1;
         end
         S_SAVE_A: begin
            bus8_src = 2'b01;
            en3      = 1'b1;
         end
         S_CALC: begin
            alu_control = opc[1:0];
            bus8_src    = 2'b10;
            push        = 1'b1;
         end
         S_POP_WR: begin
            mem_req  = 1'b1;
            adr_src  = 1'b1;
            bus8_src = 2'b01;
            write_en = mem_ready;
         end
         S_JUMP: begin
            bus5_src = 2'b01;
            pc_write = 1'b1;
         end
         S_FAULT: fault = 1'b1;
         default: fault = 1'b0;
      endcase
   end

   assign sp_count = cnt_q;

endmodule

// File: tb/tb_stack_ctrl_v2.sv
// Self-checking bench for stack_ctrl_v2: directed scenarios followed by random
// instruction streams compared against an instruction-level stack model.
module tb_stack_ctrl_v2;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   typedef struct packed {
      logic       mem_req, push, pop, ir_write, pc_write, old_pc_write, en2, en3, write_en, adr_src;
      logic [1:0] s1, s2, bus5_src, bus8_src, alu_control;
      logic       fault;
   } outs_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [2:0]       opc;
   logic             zero, mem_ready;
   logic             mem_req, push, pop, ir_write, pc_write, old_pc_write;
   logic             en2, en3, write_en, adr_src, fault;
   logic [1:0]       s1, s2, bus5_src, bus8_src, alu_control;
   logic [CNT_W-1:0] sp_count;
`ifdef FAULT_RECOVER_EN
   logic             fault_clr = 1'b0;
`endif

   int    n_checks = 0;
   int    n_errors = 0;
   int    model_sp = 0;
   bit    model_fault = 1'b0;
   outs_t obs_s;

   always #5 clk = ~clk;

   assign obs_s = {mem_req, push, pop, ir_write, pc_write, old_pc_write, en2, en3, write_en,
                   adr_src, s1, s2, bus5_src, bus8_src, alu_control, fault};

   stack_ctrl_v2 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .opc(opc), .zero(zero), .mem_ready(mem_ready),
`ifdef FAULT_RECOVER_EN
      .fault_clr(fault_clr),
`endif
      .mem_req(mem_req), .push(push), .pop(pop), .ir_write(ir_write), .pc_write(pc_write),
      .old_pc_write(old_pc_write), .en2(en2), .en3(en3), .write_en(write_en), .adr_src(adr_src),
      .s1(s1), .s2(s2), .bus5_src(bus5_src), .bus8_src(bus8_src), .alu_control(alu_control),
      .sp_count(sp_count), .fault(fault)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic outs_t if_outs(input logic rdy);
      outs_t e = '0;
      e.mem_req = 1'b1; e.s1 = 2'b01; e.s2 = 2'b01; e.bus5_src = 2'b10;
      e.ir_write = rdy; e.pc_write = rdy; e.old_pc_write = rdy;
      return e;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Check one cycle at the falling edge, then advance just past the next rising edge.
   task automatic expect_cycle(input string tag, input outs_t e, input int sp_exp);
      @(negedge clk);
      check_val(tag, 32'(obs_s), 32'(e));
      check_val({tag, "_sp"}, 32'(sp_count), 32'(sp_exp));
      @(posedge clk);
      #1;
   endtask

   task automatic reset_now();
      reset_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      check_val("rst_outs", 32'(obs_s), 32'(if_outs(1'b0)));
      check_val("rst_sp", 32'(sp_count), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_sp = 0;
      model_fault = 1'b0;
   endtask

   task automatic fault_cycles(input int n);
      outs_t e = '0;
      e.fault = 1'b1;
      for (int i = 0; i < n; i++) begin
         mem_ready = rnd_bit();
         expect_cycle("fault", e, model_sp);
      end
   endtask

   task automatic leave_fault();
`ifdef FAULT_RECOVER_EN
      outs_t e = '0;
      e.fault = 1'b1;
      fault_clr = 1'b1;
      mem_ready = rnd_bit();
      expect_cycle("fault_clr", e, model_sp);
      fault_clr = 1'b0;
      model_sp = 0;
      model_fault = 1'b0;
`else
      reset_now();
`endif
   endtask

   // One full instruction: fetch with wait states, decode, then the execution path.
   task automatic run_instr(input logic [2:0] op, input logic z, input int waits, input bit abort_push);
      outs_t e;
      bit    viol;
      int    w;
      opc = op;
      zero = z;
      for (int i = 0; i < waits; i++) begin
         mem_ready = 1'b0;
         expect_cycle("if_wait", if_outs(1'b0), model_sp);
      end
      mem_ready = 1'b1;
      expect_cycle("if_done", if_outs(1'b1), model_sp);
      mem_ready = rnd_bit();
      e = '0; e.s1 = 2'b10; e.s2 = 2'b10;
      expect_cycle("id", e, model_sp);
      case (op)
         OP_PUSH:        viol = (model_sp == DEPTH);
         OP_POP, OP_NOT: viol = (model_sp < 1);
         OP_JMP, OP_JZ:  viol = 1'b0;
         default:        viol = (model_sp < 2);
      endcase
      if (viol) begin
         model_fault = 1'b1;
         fault_cycles(2);
         return;
      end
      w = $urandom_range(0, 2);
      if (op == OP_PUSH) begin
         e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1;
         if (abort_push) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check_val("push_rd_abort", 32'(obs_s), 32'(e));
            #2;
            reset_now();
            return;
         end
         for (int i = 0; i < w; i++) begin
            mem_ready = 1'b0;
            expect_cycle("push_rd_wait", e, model_sp);
         end
         mem_ready = 1'b1;
         e.push = 1'b1;
         expect_cycle("push_rd", e, model_sp);
         model_sp++;
      end else if (op == OP_JMP || (op == OP_JZ && z)) begin
         mem_ready = rnd_bit();
         e = '0; e.bus5_src = 2'b01; e.pc_write = 1'b1;
         expect_cycle("jump", e, model_sp);
      end else if (op != OP_JZ) begin
         mem_ready = rnd_bit();
         e = '0; e.pop = 1'b1;
         expect_cycle("first_pop", e, model_sp);
         model_sp--;
         if (op == OP_POP) begin
            e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; e.bus8_src = 2'b01;
            for (int i = 0; i < w; i++) begin
               mem_ready = 1'b0;
               expect_cycle("pop_wr_wait", e, model_sp);
            end
            mem_ready = 1'b1;
            e.write_en = 1'b1;
            expect_cycle("pop_wr", e, model_sp);
         end else begin
            mem_ready = rnd_bit();
            e = '0; e.bus8_src = 2'b01; e.en2 = 1'b1;
            expect_cycle("save_b", e, model_sp);
            if (op != OP_NOT) begin
               e = '0; e.pop = 1'b1;
               expect_cycle("second_pop", e, model_sp);
               model_sp--;
               e = '0; e.bus8_src = 2'b01; e.en3 = 1'b1;
               expect_cycle("save_a", e, model_sp);
            end
            mem_ready = rnd_bit();
            e = '0; e.alu_control = op[1:0]; e.bus8_src = 2'b10; e.push = 1'b1;
            expect_cycle("calc", e, model_sp);
            model_sp++;
         end
      end
   endtask

   initial begin
      reset_n = 1'b1;
      opc = 3'b000;
      zero = 1'b0;
      mem_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_val("reset_outs", 32'(obs_s), 32'(if_outs(1'b0)));
      check_val("reset_sp", 32'(sp_count), 32'd0);
      mem_ready = 1'b1;
      #1;
      check_val("reset_outs_rdy", 32'(obs_s), 32'(if_outs(1'b1)));
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      run_instr(OP_PUSH, 1'b0, 3, 1'b0);
      run_instr(OP_PUSH, 1'b0, 0, 1'b0);
      run_instr(OP_ADD,  1'b0, 0, 1'b0);
      run_instr(OP_NOT,  1'b0, 1, 1'b0);
      run_instr(OP_JZ,   1'b0, 0, 1'b0);
      run_instr(OP_JZ,   1'b1, 0, 1'b0);
      run_instr(OP_JMP,  1'b0, 2, 1'b0);
      run_instr(OP_SUB,  1'b0, 0, 1'b0);
      leave_fault();

      for (int i = 0; i < DEPTH + 1; i++) run_instr(OP_PUSH, 1'b0, 0, 1'b0);
      leave_fault();

      run_instr(OP_PUSH, 1'b0, 1, 1'b0);
      run_instr(OP_POP,  1'b0, 0, 1'b0);
      run_instr(OP_PUSH, 1'b0, 0, 1'b0);
      run_instr(OP_PUSH, 1'b0, 0, 1'b1);

      for (int i = 0; i < 250; i++) begin
         if (model_fault) leave_fault();
         run_instr(3'($urandom_range(0, 7)), rnd_bit(), $urandom_range(0, 3), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
